// File: rtl/lane_pkg.sv
// Shared types for the lane scroll engine: frame FSM states, per-lane move codes
// and the row-major frame packing helper.
package lane_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      INJECT,
      MOVE,
      CHECK,
      PUBLISH
   } state_e;

   typedef enum logic [1:0] {
      HOLD  = 2'b00,
      LEFT  = 2'b01,
      RIGHT = 2'b10
   } move_code_e;

   // Bit offset of (row, lane) inside the packed, row-major frame vector.
   function automatic int frame_index(input int row, input int lane,
                                      input int n_lanes, input int lane_w);
      return (row * n_lanes + lane) * lane_w;
   endfunction

endpackage

// File: rtl/lane_unit.sv
// One player lane: car column with clamped movement, crash immunity counter and
// collision detection against the two playfield rows under the car.
module lane_unit
   import lane_pkg::*;
#(
   parameter int LANE_W    = 6,
   parameter int IMMUNE_FR = 3
) (
   input  logic                       clk,
   input  logic                       RST,
   input  logic                       move_en,
   input  logic                       check_en,
   input  logic [1:0]                 move_req,
   input  logic [LANE_W-1:0]          head_row,
   input  logic [LANE_W-1:0]          tail_row,
   output logic [$clog2(LANE_W)-1:0]  col,
   output logic [$clog2(LANE_W)-1:0]  car_pos,
   output logic                       crash
);

   localparam int CW = $clog2(LANE_W);

   logic [3:0] immune;
   logic       hit;

   assign hit   = head_row[col] | tail_row[col];
   assign crash = check_en & hit & (immune == 4'd0);

   // Working column moves in MOVE so CHECK sees the new position.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         col <= CW'(LANE_W / 2);
      end else if (move_en) begin
         case (move_code_e'(move_req))
            LEFT: begin
               if (col != '0) col <= col - CW'(1);
            end
            RIGHT: begin
               if (col != CW'(LANE_W - 1)) col <= col + CW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         immune  <= '0;
         car_pos <= CW'(LANE_W / 2);
      end else if (check_en) begin
         car_pos <= col;
         if (crash) begin
            immune <= 4'(IMMUNE_FR);
         end else if (immune != 4'd0) begin
            immune <= immune - 4'd1;
         end
      end
   end

endmodule

// File: rtl/lane_scroll_engine.sv
// Multi-lane scrolling obstacle game core: owns the shared playfield, frame FSM,
// cross-lane scoring and the frame handshake toward the display driver.
module lane_scroll_engine
   import lane_pkg::*;
#(
   parameter int N_LANES    = 2,
   parameter int LANE_W     = 6,
   parameter int DEPTH      = 24,
   parameter int CAR_ROW    = 16,
   parameter int INJECT_DIV = 4,
   parameter int IMMUNE_FR  = 3,
   parameter int SCORE_W    = 6
) (
   input  logic                                 clk,
   input  logic                                 RST,
   input  logic                                 tick,
   input  logic [N_LANES*LANE_W-1:0]            obstacle_rnd,
   input  logic [N_LANES*LANE_W-1:0]            force_obst,
   input  logic [2*N_LANES-1:0]                 move_req,
   output logic [N_LANES*LANE_W*DEPTH-1:0]      frame_data,
   output logic                                 frame_valid,
   input  logic                                 frame_ready,
   output logic [N_LANES-1:0]                   crash,
   output logic [N_LANES*SCORE_W-1:0]           score,
   output logic [N_LANES*$clog2(LANE_W)-1:0]    car_pos,
   output logic                                 tick_overrun
);

   localparam int CW    = $clog2(LANE_W);
   localparam int ROW_W = N_LANES * LANE_W;
   localparam int FW    = ROW_W * DEPTH;
   localparam int SMAX  = (1 << SCORE_W) - 1;

   state_e state, state_next;
   logic   shift_en, inject_en, move_en, check_en;

   logic [ROW_W-1:0]   field [DEPTH];
   logic [7:0]         inject_cnt;
   logic [N_LANES-1:0] crash_now;
   logic [CW-1:0]      col [N_LANES];
   logic [LANE_W-1:0]  car_mask [N_LANES];
   logic [FW-1:0]      frame_next;
   logic [SCORE_W-1:0] score_q [N_LANES];
   logic [SCORE_W-1:0] score_next [N_LANES];

   always_ff @(posedge clk or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (tick) state_next = SHIFT;
         SHIFT:   state_next = INJECT;
         INJECT:  state_next = MOVE;
         MOVE:    state_next = CHECK;
         CHECK:   state_next = PUBLISH;
         PUBLISH: if (frame_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      shift_en    = 1'b0;
      inject_en   = 1'b0;
      move_en     = 1'b0;
      check_en    = 1'b0;
      frame_valid = 1'b0;
      case (state)
         SHIFT:   shift_en    = 1'b1;
         INJECT:  inject_en   = 1'b1;
         MOVE:    move_en     = 1'b1;
         CHECK:   check_en    = 1'b1;
         PUBLISH: frame_valid = 1'b1;
         default: ;
      endcase
   end

   // Row 0 is left stale by SHIFT; INJECT always rewrites it one cycle later.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         for (int r = 0; r < DEPTH; r++) field[r] <= '0;
         inject_cnt <= '0;
      end else if (shift_en) begin
         for (int r = 1; r < DEPTH; r++) field[r] <= field[r-1];
      end else if (inject_en) begin
         if (inject_cnt == 8'(INJECT_DIV - 1)) begin
            field[0]   <= obstacle_rnd | force_obst;
            inject_cnt <= '0;
         end else begin
            field[0]   <= '0;
            inject_cnt <= inject_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST)                        tick_overrun <= 1'b0;
      else if (tick && state != IDLE) tick_overrun <= 1'b1;
   end

   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      lane_unit #(
         .LANE_W    (LANE_W),
         .IMMUNE_FR (IMMUNE_FR)
      ) u_lane (
         .clk      (clk),
         .RST      (RST),
         .move_en  (move_en),
         .check_en (check_en),
         .move_req (move_req[2*i +: 2]),
         .head_row (field[CAR_ROW][i*LANE_W +: LANE_W]),
         .tail_row (field[CAR_ROW+1][i*LANE_W +: LANE_W]),
         .col      (col[i]),
         .car_pos  (car_pos[i*CW +: CW]),
         .crash    (crash_now[i])
      );
      assign car_mask[i]                   = LANE_W'(1) << col[i];
      assign score[i*SCORE_W +: SCORE_W]   = score_q[i];
   end

   always_comb begin
      frame_next = '0;
      for (int r = 0; r < DEPTH; r++) begin
         for (int i = 0; i < N_LANES; i++) begin
            frame_next[frame_index(r, i, N_LANES, LANE_W) +: LANE_W] =
               field[r][i*LANE_W +: LANE_W] |
               (((r == CAR_ROW) || (r == CAR_ROW + 1)) ? car_mask[i] : '0);
         end
      end
   end

   // Each crashing lane credits every other lane once, saturating.
   always_comb begin
      int gain;
      gain = 0;
      for (int j = 0; j < N_LANES; j++) begin
         gain = 0;
         for (int i = 0; i < N_LANES; i++) begin
            if (i != j && crash_now[i]) gain = gain + 1;
         end
         if (int'(score_q[j]) + gain > SMAX) score_next[j] = SCORE_W'(SMAX);
         else                                score_next[j] = score_q[j] + SCORE_W'(gain);
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         for (int j = 0; j < N_LANES; j++) score_q[j] <= '0;
      end else if (check_en) begin
         for (int j = 0; j < N_LANES; j++) score_q[j] <= score_next[j];
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         crash      <= '0;
         frame_data <= '0;
      end else begin
         crash <= check_en ? crash_now : '0;
         if (check_en) frame_data <= frame_next;
      end
   end

endmodule

// File: doc/lane_scroll_engine.md
LANE_SCROLL_ENGINE -- requirements
Module: lane_scroll_engine

Interface
REQ-001 Parameter N_LANES, default 2, number of independent player lanes (1..8).
REQ-002 Parameter LANE_W, default 6, playable columns per lane (2..16).
REQ-003 Parameter DEPTH, default 24, scroll rows per lane.
REQ-004 Parameter CAR_ROW, default 16, row holding the car head; car tail at CAR_ROW+1; CAR_ROW+1 < DEPTH.
REQ-005 Parameter INJECT_DIV, default 4, frames per obstacle injection (1..255).
REQ-006 Parameter IMMUNE_FR, default 3, frames of crash immunity (0..15).
REQ-007 Parameter SCORE_W, default 6, score counter width.
REQ-008 clk  in  1  single system clock, all logic on rising edge.
REQ-009 RST  in  1  reset, asynchronous, active-high.
REQ-010 tick  in  1  one-cycle frame-advance strobe.
REQ-011 obstacle_rnd  in  N_LANES*LANE_W  random obstacle row, lane i at bits [i*LANE_W +: LANE_W].
REQ-012 force_obst  in  N_LANES*LANE_W  forced obstacle bits, same packing.
REQ-013 move_req  in  2*N_LANES  per lane: 00 hold, 01 left (column-1), 10 right (column+1), 11 hold.
REQ-014 frame_data  out  N_LANES*LANE_W*DEPTH  composed frame, row-major: row r, lane i at [(r*N_LANES+i)*LANE_W +: LANE_W].
REQ-015 frame_valid  out  1  frame_data valid.
REQ-016 frame_ready  in  1  downstream display driver accepts frame.
REQ-017 crash  out  N_LANES  one-cycle crash pulse per lane.
REQ-018 score  out  N_LANES*SCORE_W  per-lane win count.
REQ-019 car_pos  out  N_LANES*$clog2(LANE_W)  current car column per lane.
REQ-020 tick_overrun  out  1  sticky flag, tick arrived while not IDLE.

Function
REQ-021 FSM states IDLE, SHIFT, INJECT, MOVE, CHECK, PUBLISH; one cycle each except IDLE and PUBLISH.
REQ-022 IDLE: tick=1 -> SHIFT next cycle; else stay.
REQ-023 SHIFT: every row r>0 takes row r-1, all lanes in parallel; row DEPTH-1 contents discarded.
REQ-024 INJECT: if inject counter = INJECT_DIV-1, row 0 = obstacle_rnd | force_obst and counter wraps to 0; else row 0 = 0 and counter +1.
REQ-025 MOVE: 01 decrements car column, 10 increments; clamp at 0 and LANE_W-1 (no wrap); 00/11 hold.
REQ-026 CHECK: lane crashes if playfield bit at (CAR_ROW, new column) or (CAR_ROW+1, new column) is 1 and immunity counter = 0.
REQ-027 On crash of lane i: immunity counter(i) loads IMMUNE_FR; every other lane's score increments by 1, saturating at 2^SCORE_W-1.
REQ-028 Simultaneous crashes in several lanes: each crashing lane credits all other lanes, so a lane may gain up to N_LANES-1 in one frame (saturating).
REQ-029 Immunity counter decrements once per processed frame in CHECK when non-zero and no crash.
REQ-030 CHECK -> PUBLISH; frame_data latched as playfield OR car bits at CAR_ROW and CAR_ROW+1; crash pulses high for exactly the first PUBLISH cycle.
REQ-031 Latency: tick sampled in IDLE at cycle t -> frame_valid and crash high at cycle t+5.
REQ-032 PUBLISH: frame_valid=1, frame_data stable until frame_valid & frame_ready; transfer cycle -> IDLE next cycle, frame_valid low.
REQ-033 tick outside IDLE is dropped, no frame processed; tick_overrun sets and holds until RST.
REQ-034 score, car_pos update only in CHECK; stable otherwise.

Reset
REQ-035 RST asserted: FSM IDLE, playfield all 0, inject counter 0, immunity counters 0, car_pos = LANE_W/2 (integer), score 0, frame_data 0, frame_valid 0, crash 0, tick_overrun 0.
REQ-036 RST mid-frame or mid-PUBLISH aborts immediately; no partial frame, no crash pulse, no score change after deassertion.
REQ-037 First tick honoured is the first one sampled in IDLE after RST deasserts.

Structure
REQ-038 Package lane_pkg holds FSM state enum, move codes (HOLD, LEFT, RIGHT) and frame-index helper function.
REQ-039 Sub-module lane_unit: one per lane via generate; owns car column, immunity counter, clamp and collision logic; engine owns playfield, FSM, scores, handshake.

Verification
REQ-040 Defaults, one tick, frame_ready=1, no obstacles -> frame_valid at t+5, only car bits set (column 3 rows 16,17 per lane), scores 0.
REQ-041 force_obst lane0 bit 3, 20 ticks -> obstacle inserted on 4th frame, reaches row 16 on 20th frame; crash[0] pulses, score lane1 = 1, score lane0 = 0.
REQ-042 Same obstacle column stream continuous, IMMUNE_FR=3 -> crash[0] at most once per 4 frames; score lane1 increments accordingly.
REQ-043 Lane0 move_req=01 for 5 ticks from column 3 -> car_pos 2,1,0,0,0; move_req=11 -> holds.
REQ-044 frame_ready=0 for 10 cycles, tick at PUBLISH -> frame_data stable, tick_overrun=1, no extra frame after ready.
REQ-045 RST pulse during SHIFT after 3 scored crashes -> all outputs at reset values, score 0, car_pos 3, next tick yields clean frame at t+5.
